// File: rtl/fma_dot_seq.sv
// Dot-product sequencer around an external single-cycle combinational FMA.
// Streams len operand pairs through the FMA, accumulating a*b+acc, then presents the sum.
module fma_dot_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends combinationally on valid, and the result stays stable while valid waits for ready.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      fma_a,
  output logic [31:0]      fma_b,
  output logic [31:0]      fma_c,
  input  logic [31:0]      fma_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             op_valid_q, op_valid_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic             accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (accept && (cnt_q == LEN_W'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The registered pair is folded into acc on the edge after it was accepted.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    op_valid_d = 1'b0;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    if (op_valid_q) begin
      acc_d = fma_out;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = len;
        end
      end
      S_RUN: begin
        if (accept) begin
          op_a_d     = in_a;
          op_b_d     = in_b;
          op_valid_d = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    in_ready  = (state_q == S_RUN);
    res_valid = (state_q == S_DONE);
    res_data  = acc_q;
    fma_a     = op_a_q;
    fma_b     = op_b_q;
    fma_c     = acc_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_fma_dot_seq.sv
// Bench for fma_dot_seq: models the external FMA on integer-valued floats and
// checks each job against an arithmetic dot-product reference.
module tb_fma_dot_seq;

  localparam int LEN_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a, in_b;
  logic [31:0]      fma_a, fma_b, fma_c;
  logic [31:0]      fma_out;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [1:0]       dbg_state;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  int          va[256];
  int          vb[256];
  logic [31:0] last_res;
  logic [31:0] res_b2b;

  fma_dot_seq #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .fma_a     (fma_a),
    .fma_b     (fma_b),
    .fma_c     (fma_c),
    .fma_out   (fma_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact conversions for integers well inside the 24-bit mantissa range.
  function automatic logic [31:0] int_to_f32(input int v);
    logic [31:0] m;
    logic [31:0] r;
    int p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int k = 0; k < 31; k++) if (m[k]) p = k;
    if (p <= 23) r = m << (23 - p);
    else         r = m >> (p - 23);
    return {(v < 0), 8'(p + 127), r[22:0]};
  endfunction

  function automatic int f32_to_int(input logic [31:0] f);
    int e;
    logic [31:0] m;
    int mag;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    if (e < 0)        mag = 0;
    else if (e <= 23) mag = int'(m >> (23 - e));
    else if (e <= 30) mag = int'(m << (e - 23));
    else              mag = 0;
    return f[31] ? -mag : mag;
  endfunction

  // external combinational FMA
  always_comb fma_out = int_to_f32(f32_to_int(fma_a) * f32_to_int(fma_b) + f32_to_int(fma_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One complete job: start, operand stream with gaps, result held for rr_hold cycles, handshake.
  task automatic run_job(input int n, input int min_gap, input int max_gap, input int rr_hold);
    int sent, acc_m, pend_val, gap, cyc, exp_sum;
    bit pend, acc_now;
    logic [31:0] pa, pb, held;
    exp_sum = 0;
    for (int i = 0; i < n; i++) exp_sum += va[i] * vb[i];
    exp_q.push_back(int_to_f32(exp_sum));
    sent = 0; acc_m = 0; pend_val = 0; pend = 0; cyc = 0; pa = '0; pb = '0;
    start = 1'b1; len = LEN_W'(n);
    tick();
    start = 1'b0; len = LEN_W'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    gap = $urandom_range(max_gap, min_gap);
    while ((sent < n || pend) && cyc < 600) begin
      check("in_ready_run", 32'(in_ready), 32'(sent < n));
      check("fma_c_acc", fma_c, int_to_f32(acc_m));
      check("res_valid_run", 32'(res_valid), 32'd0);
      if (pend) begin
        check("fma_a_op", fma_a, pa);
        check("fma_b_op", fma_b, pb);
      end
      acc_now = 1'b0;
      if (sent < n && gap == 0) begin
        in_valid = 1'b1;
        in_a = int_to_f32(va[sent]);
        in_b = int_to_f32(vb[sent]);
        acc_now = 1'b1;
      end else begin
        in_valid = (sent >= n) ? 1'($urandom) : 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        if (gap > 0) gap--;
      end
      start = 1'($urandom);
      tick();
      cyc++;
      start = 1'b0;
      if (pend) begin
        acc_m += pend_val;
        pend = 1'b0;
      end
      if (acc_now) begin
        pend = 1'b1;
        pend_val = va[sent] * vb[sent];
        pa = in_a;
        pb = in_b;
        sent++;
        gap = $urandom_range(max_gap, min_gap);
      end
      in_valid = 1'b0;
    end
    if (cyc >= 600) begin
      checks++;
      failures++;
      $error("FAIL job_timeout observed=%0d expected_pairs=%0d", sent, n);
    end
    check("res_valid_done", 32'(res_valid), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
    check("res_data_acc", res_data, int_to_f32(acc_m));
    held = res_data;
    for (int h = 0; h < rr_hold; h++) begin
      start = 1'($urandom);
      len = LEN_W'($urandom);
      in_valid = 1'($urandom);
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      check("res_valid_hold", 32'(res_valid), 32'd1);
      check("res_data_hold", res_data, held);
    end
    res_ready = 1'b1;
    start = 1'b1;
    len = LEN_W'(3);
    last_res = res_data;
    check("scoreboard", res_data, exp_q.pop_front());
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    check("res_valid_after_done", 32'(res_valid), 32'd0);
    tick();
    check("start_ignored_at_handshake", 32'(busy), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    last_res = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_fma_a", fma_a, 32'h0);
    check("rst_fma_b", fma_b, 32'h0);
    check("rst_fma_c", fma_c, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    // single pair 1.0 * 2.0
    va[0] = 1; vb[0] = 2;
    run_job(1, 0, 0, 0);
    check("single_pair_result", last_res, 32'h40000000);

    // three pairs back to back: 2 + 12 + 1
    va[0] = 1; vb[0] = 2; va[1] = 3; vb[1] = 4; va[2] = 1; vb[2] = 1;
    run_job(3, 0, 0, 1);
    check("three_pair_result", last_res, 32'h41700000);

    // two pairs, back to back and then with 4-cycle bubbles
    va[0] = 1; vb[0] = 2; va[1] = 3; vb[1] = 4;
    run_job(2, 0, 0, 0);
    res_b2b = last_res;
    run_job(2, 4, 4, 0);
    check("gap_equals_b2b", last_res, res_b2b);
    check("two_pair_result", last_res, 32'h41600000);

    // empty job
    run_job(0, 0, 0, 2);
    check("len0_result", last_res, 32'h0);

    // result held with res_ready low for 5 cycles
    va[0] = 5; vb[0] = -3;
    run_job(1, 0, 0, 5);
    check("negative_result", last_res, 32'hC1700000);

    // reset at the second accept of a len=4 job
    start = 1'b1; len = LEN_W'(4);
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
    tick();
    in_a = 32'h40400000; in_b = 32'h40800000; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_in_ready", 32'(in_ready), 32'd0);
    check("midrun_rst_res_valid", 32'(res_valid), 32'd0);
    check("midrun_rst_res_data", res_data, 32'h0);
    check("midrun_rst_fma_a", fma_a, 32'h0);
    check("midrun_rst_fma_b", fma_b, 32'h0);
    check("midrun_rst_fma_c", fma_c, 32'h0);
    tick();
    check("midrun_rst_stays_idle", 32'(busy), 32'd0);
    va[0] = 1; vb[0] = 2;
    run_job(1, 0, 0, 0);
    check("after_rst_result", last_res, 32'h40000000);

    // reset while a result is waiting
    start = 1'b1; len = '0;
    tick();
    start = 1'b0;
    check("done_before_rst", 32'(res_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("middone_rst_res_valid", 32'(res_valid), 32'd0);
    check("middone_rst_busy", 32'(busy), 32'd0);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) begin
        va[i] = int'($urandom_range(15, 0)) - 7;
        vb[i] = int'($urandom_range(15, 0)) - 7;
      end
      run_job(n, 0, 3, int'($urandom_range(3, 0)));
    end

    // maximum length, back to back
    for (int i = 0; i < 255; i++) begin
      va[i] = int'($urandom_range(8, 0)) - 4;
      vb[i] = int'($urandom_range(8, 0)) - 4;
    end
    run_job(255, 0, 0, 1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
